lagarto_plic_target: RTL and testbench

- PLIC core/target-side counterpart to the per-source gateways.
- Captures gateway interrupt requests into per-source pending bits and arbitrates by priority against a threshold.
- Drives the external-interrupt-pending line to one hart context and services claim/complete.
- Returns per-source completion enables to the gateways so each gateway re-opens only after its interrupt is completed.

---
 rtl/lagarto_plic_target.sv | 94 +++++++++
 tb/tb_lagarto_plic_target.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lagarto_plic_target.sv
// PLIC target: latches gateway requests as pending, arbitrates by priority over a threshold, serves claim/complete.
// eip_o and claim response registered (one cycle); interrupt_complete_o re-opens a gateway only once its source is idle.
module lagarto_plic_target #(
    parameter int unsigned N_SOURCES  = 8,
    parameter int unsigned PRIO_WIDTH = 3,
    parameter int unsigned ID_WIDTH   = $clog2(N_SOURCES)
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [N_SOURCES-1:0]             interrupt_request_i,
    input  logic [N_SOURCES*PRIO_WIDTH-1:0]  priority_i,
    input  logic [PRIO_WIDTH-1:0]            threshold_i,
    input  logic                             claim_i,
    input  logic                             complete_i,
    input  logic [ID_WIDTH-1:0]              complete_id_i,
    output logic [ID_WIDTH-1:0]              claim_id_o,
    output logic                             claim_valid_o,
    output logic                             eip_o,
    output logic [N_SOURCES-1:0]             interrupt_complete_o
);

    // A source is IDLE when neither its pending nor its claimed bit is set.
    logic [N_SOURCES-1:0]  pend_q, pend_d;
    logic [N_SOURCES-1:0]  clmd_q, clmd_d;
    logic [N_SOURCES-1:0]  ic_q, ic_d;
    logic                  eip_q;
    logic [ID_WIDTH-1:0]   claim_id_q;
    logic                  claim_vld_q;

    logic [ID_WIDTH-1:0]   win_id;
    logic [PRIO_WIDTH-1:0] best_prio;
    logic                  any_elig;

    // Starting the running best at the threshold makes "priority > threshold" and
    // "priority 0 never wins" fall out; strict compare keeps the lowest ID on ties.
    always_comb begin
        win_id    = '0;
        best_prio = threshold_i;
        any_elig  = 1'b0;
        for (int i = 0; i < int'(N_SOURCES); i++) begin
            if (i != 0 && pend_q[i] && priority_i[i*PRIO_WIDTH +: PRIO_WIDTH] > best_prio) begin
                best_prio = priority_i[i*PRIO_WIDTH +: PRIO_WIDTH];
                win_id    = ID_WIDTH'(i);
                any_elig  = 1'b1;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        clmd_d = clmd_q;
        for (int i = 0; i < int'(N_SOURCES); i++) begin
            if (i != 0 && !pend_q[i] && !clmd_q[i] && interrupt_request_i[i]) begin
                pend_d[i] = 1'b1;
            end
            if (claim_i && any_elig && win_id == ID_WIDTH'(i)) begin
                pend_d[i] = 1'b0;
                clmd_d[i] = 1'b1;
            end
            if (complete_i && clmd_q[i] && complete_id_i == ID_WIDTH'(i)) begin
                clmd_d[i] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
        clmd_d[0] = 1'b0;
        ic_d      = ~(pend_d | clmd_d);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q      <= '0;
            clmd_q      <= '0;
            ic_q        <= '1;
            eip_q       <= 1'b0;
            claim_id_q  <= '0;
            claim_vld_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            clmd_q      <= clmd_d;
            ic_q        <= ic_d;
            eip_q       <= any_elig;
            claim_vld_q <= claim_i;
            if (claim_i) begin
                claim_id_q <= win_id;
            end
        end
    end

    assign claim_id_o           = claim_id_q;
    assign claim_valid_o        = claim_vld_q;
    assign eip_o                = eip_q;
    assign interrupt_complete_o = ic_q;

endmodule

// File: tb/tb_lagarto_plic_target.sv
// Randomized + directed bench for lagarto_plic_target with a per-source state model and scoreboard queues.
module tb_lagarto_plic_target;
    localparam int N  = 8;
    localparam int PW = 3;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*PW-1:0] prio_vec;
    logic [PW-1:0]   thr_v;
    logic            claim, comp;
    logic [IW-1:0]   cid;
    logic [IW-1:0]   claim_id_o;
    logic            claim_valid_o, eip_o;
    logic [N-1:0]    ic_o;

    lagarto_plic_target #(.N_SOURCES(N), .PRIO_WIDTH(PW), .ID_WIDTH(IW)) dut (
        .clk_i(clk), .rstn_i(rstn), .interrupt_request_i(req), .priority_i(prio_vec),
        .threshold_i(thr_v), .claim_i(claim), .complete_i(comp), .complete_id_i(cid),
        .claim_id_o(claim_id_o), .claim_valid_o(claim_valid_o), .eip_o(eip_o),
        .interrupt_complete_o(ic_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: 0 = idle, 1 = pending, 2 = claimed
    int st [N];
    int pr [N];
    int thr;

    typedef struct packed {
        logic         eip;
        logic         cvld;
        logic [N-1:0] ic;
    } status_t;

    status_t  sq[$];
    int       cq[$];
    bit       mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && sq.size() > 0) begin
            status_t s;
            s = sq.pop_front();
            chk("eip", 64'(eip_o), 64'(s.eip));
            chk("claim_valid", 64'(claim_valid_o), 64'(s.cvld));
            chk("int_complete", 64'(ic_o), 64'(s.ic));
            if (claim_valid_o) begin
                if (cq.size() == 0) chk("claim_unexpected", 64'(1), 64'(0));
                else                chk("claim_id", 64'(claim_id_o), 64'(cq.pop_front()));
            end
        end
    end

    task automatic model_step(input logic [N-1:0] r, input logic c, input logic k, input int id);
        int      best = -1;
        int      win  = 0;
        int      nst [N];
        status_t s;
        for (int i = 1; i < N; i++)
            if (st[i] == 1 && pr[i] > thr && pr[i] > best) best = pr[i];
        for (int i = N - 1; i >= 1; i--)
            if (st[i] == 1 && pr[i] == best && best > thr) win = i;
        for (int i = 0; i < N; i++) begin
            nst[i] = st[i];
            if (i == 0) continue;
            if (st[i] == 0 && r[i]) nst[i] = 1;
            if (st[i] == 1 && c && win == i) nst[i] = 2;
            if (st[i] == 2 && k && id == i) nst[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            st[i]   = nst[i];
            s.ic[i] = (st[i] == 0);
        end
        s.eip  = (best > thr);
        s.cvld = c;
        if (c) cq.push_back(win);
        sq.push_back(s);
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic c = 1'b0, input logic k = 1'b0, input int id = 0);
        @(negedge clk);
        req   = r;
        claim = c;
        comp  = k;
        cid   = IW'(id);
        for (int i = 0; i < N; i++) prio_vec[i*PW +: PW] = PW'(pr[i]);
        thr_v = PW'(thr);
        model_step(r, c, k, id);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc('0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_eip"}, 64'(eip_o), 64'(0));
        chk({tag, "_claim_id"}, 64'(claim_id_o), 64'(0));
        chk({tag, "_claim_valid"}, 64'(claim_valid_o), 64'(0));
        chk({tag, "_ic"}, 64'(ic_o), 64'(8'hFF));
    endtask

    // Reset asynchronously while a claim response is being presented.
    task automatic mid_claim_reset();
        @(negedge clk);
        mon_en = 1'b0;
        sq.delete();
        cq.delete();
        claim = 1'b1;
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        for (int i = 0; i < N; i++) st[i] = 0;
        @(negedge clk);
        claim = 1'b0;
        comp  = 1'b0;
        req   = '0;
        rstn  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; req = '0; claim = 1'b0; comp = 1'b0; cid = '0;
        thr = 0; thr_v = '0; prio_vec = '0;
        for (int i = 0; i < N; i++) begin st[i] = 0; pr[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;
        mon_en = 1'b1;

        // Single source full cycle
        pr[3] = 2;
        cyc(8'h08); idle(2);
        cyc('0, 1'b1); idle(2);
        cyc('0, 1'b0, 1'b1, 3); idle(1);

        // Ties and ordering: expect 2, 5, 6, 0
        pr[2] = 5; pr[5] = 5; pr[6] = 4;
        cyc(8'h64); idle(2);
        for (int j = 0; j < 4; j++) begin cyc('0, 1'b1); idle(1); end

        // Claim of 5 together with complete of 2
        cyc('0, 1'b0, 1'b1, 5); cyc(8'h20); idle(1);
        cyc('0, 1'b1, 1'b1, 2); idle(1);
        // Request 2 held high across its own complete
        cyc(8'h04); idle(1); cyc('0, 1'b1); idle(1);
        cyc(8'h04, 1'b0, 1'b1, 2); cyc(8'h04); idle(2);

        mid_claim_reset();

        // Threshold masking
        for (int i = 0; i < N; i++) pr[i] = 0;
        thr = 4; pr[1] = 4;
        cyc(8'h02); idle(2);
        cyc('0, 1'b1); idle(1);
        thr = 3; idle(2);

        // Bogus completes
        pr[4] = 1;
        cyc(8'h10); idle(1);
        cyc('0, 1'b0, 1'b1, 0);
        cyc('0, 1'b0, 1'b1, 7);
        cyc('0, 1'b0, 1'b1, 4);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [N-1:0] r;
            if (n % 60 == 0) begin
                for (int i = 1; i < N; i++) pr[i] = $urandom_range(0, 7);
                thr = $urandom_range(0, 4);
            end
            r = N'($urandom) & N'($urandom);
            cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
        end
        idle(3);
        chk("claim_queue_drained", 64'(cq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
